// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch-taken and
// the data-memory handshake into per-stage controls, with a wait watchdog and stall counter.
module pipeline_stall_controller #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hazard_i,
  input  logic             branch_taken_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_write_o,
  output logic             memwb_bubble_o,
  output logic             busy_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_count_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MEM_DONE = 2'd2,
    ST_ERR      = 2'd3
  } state_t;

  state_t             state_q;
  logic               mem_req_q;
  logic               timeout_q;
  logic [TO_W-1:0]    wd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               acc_s;
  logic               freeze_s;

  assign acc_s = mem_read_i | mem_write_i;

  always_comb begin
    freeze_s = 1'b0;
    case (state_q)
      ST_RUN:      freeze_s = acc_s;
      ST_MEM_WAIT: freeze_s = 1'b1;
      ST_MEM_DONE: freeze_s = 1'b0;
      ST_ERR:      freeze_s = 1'b1;
      default:     freeze_s = 1'b1;
    endcase
  end

  // Per-stage controls; hazard outranks branch so a taken branch is re-resolved next cycle.
  always_comb begin
    pc_write_o     = 1'b1;
    ifid_write_o   = 1'b1;
    exmem_write_o  = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    memwb_bubble_o = 1'b0;
    if (rst_i) begin
      pc_write_o = 1'b1;
    end else if (freeze_s) begin
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      exmem_write_o  = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (hazard_i) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
    end else begin
      ifid_flush_o = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!pc_write_o && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      mem_req_q <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= {TO_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        ST_RUN: begin
          if (acc_s) begin
            state_q   <= ST_MEM_WAIT;
            mem_req_q <= 1'b1;
            wd_q      <= {TO_W{1'b0}};
          end
        end
        ST_MEM_WAIT: begin
          // An ack on the expiry edge still completes the access.
          if (mem_ack_i) begin
            state_q   <= ST_MEM_DONE;
            mem_req_q <= 1'b0;
          end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
            state_q   <= ST_ERR;
            mem_req_q <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            wd_q <= wd_q + {{(TO_W-1){1'b0}}, 1'b1};
          end
        end
        ST_MEM_DONE: state_q <= ST_RUN;
        ST_ERR:      state_q <= ST_ERR;
        default: begin
          state_q   <= ST_ERR;
          mem_req_q <= 1'b0;
          timeout_q <= 1'b1;
        end
      endcase
    end
  end

  assign mem_req_o     = mem_req_q;
  assign timeout_o     = timeout_q;
  assign stall_count_o = cnt_q;
  assign busy_o        = (state_q == ST_MEM_WAIT) || (state_q == ST_ERR);

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with TIMEOUT=4; expected values are hand-computed.
module tb_pipeline_stall_controller;

  logic        clk_i = 1'b0;
  logic        rst_i, hazard_i, branch_taken_i, mem_read_i, mem_write_i, mem_ack_i;
  logic        mem_req_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o;
  logic        exmem_write_o, memwb_bubble_o, busy_o, timeout_o;
  logic [31:0] stall_count_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  pipeline_stall_controller #(.TIMEOUT(4), .TO_W(8), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .hazard_i(hazard_i), .branch_taken_i(branch_taken_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_ack_i(mem_ack_i),
    .mem_req_o(mem_req_o), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o), .exmem_write_o(exmem_write_o),
    .memwb_bubble_o(memwb_bubble_o), .busy_o(busy_o), .timeout_o(timeout_o),
    .stall_count_o(stall_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    chk_cnt++;
    if (obs === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  // Drive inputs on the falling edge, then let combinational outputs settle before checks.
  task automatic drive(input logic r, input logic h, input logic b, input logic rd,
                       input logic wr, input logic a);
    @(negedge clk_i);
    rst_i = r; hazard_i = h; branch_taken_i = b;
    mem_read_i = rd; mem_write_i = wr; mem_ack_i = a;
    #1;
  endtask

  initial begin
    rst_i = 1'b1; hazard_i = 1'b0; branch_taken_i = 1'b0;
    mem_read_i = 1'b0; mem_write_i = 1'b0; mem_ack_i = 1'b0;

    // Reset forces pass-through controls even with a hazard present.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_pc_write", {31'd0, pc_write_o}, 32'd1);
    check("rst_bubble", {31'd0, idex_bubble_o}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);

    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, i == 2);
    check("idle_pc_write", {31'd0, pc_write_o}, 32'd1);
    check("idle_ifid_write", {31'd0, ifid_write_o}, 32'd1);
    check("idle_exmem_write", {31'd0, exmem_write_o}, 32'd1);
    check("idle_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("idle_busy", {31'd0, busy_o}, 32'd0);
    check("idle_stall_cnt", stall_count_o, 32'd0);

    // Load-use hazard
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("haz_pc_write", {31'd0, pc_write_o}, 32'd0);
    check("haz_ifid_write", {31'd0, ifid_write_o}, 32'd0);
    check("haz_bubble", {31'd0, idex_bubble_o}, 32'd1);
    check("haz_exmem_write", {31'd0, exmem_write_o}, 32'd1);
    check("haz_memwb", {31'd0, memwb_bubble_o}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("haz_stall_cnt", stall_count_o, 32'd1);

    // Hazard beats branch, then branch alone flushes
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("both_bubble", {31'd0, idex_bubble_o}, 32'd1);
    check("both_flush", {31'd0, ifid_flush_o}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("br_flush", {31'd0, ifid_flush_o}, 32'd1);
    check("br_pc_write", {31'd0, pc_write_o}, 32'd1);
    check("br_ifid_write", {31'd0, ifid_write_o}, 32'd1);
    check("br_stall_cnt", stall_count_o, 32'd2);

    // Load with ack in the third wait cycle; hazard during freeze is ignored
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ld0_pc_write", {31'd0, pc_write_o}, 32'd0);
    check("ld0_exmem_write", {31'd0, exmem_write_o}, 32'd0);
    check("ld0_memwb", {31'd0, memwb_bubble_o}, 32'd1);
    check("ld0_bubble", {31'd0, idex_bubble_o}, 32'd0);
    check("ld0_mem_req", {31'd0, mem_req_o}, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, c == 3);
      check("ld_wait_mem_req", {31'd0, mem_req_o}, 32'd1);
      check("ld_wait_busy", {31'd0, busy_o}, 32'd1);
      check("ld_wait_flush", {31'd0, ifid_flush_o}, 32'd0);
      check("ld_wait_pc_write", {31'd0, pc_write_o}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ld_done_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("ld_done_busy", {31'd0, busy_o}, 32'd0);
    check("ld_done_pc_write", {31'd0, pc_write_o}, 32'd1);
    check("ld_done_exmem_write", {31'd0, exmem_write_o}, 32'd1);
    check("ld_done_memwb", {31'd0, memwb_bubble_o}, 32'd0);
    check("ld_done_stall_cnt", stall_count_o, 32'd6);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ld_after_pc_write", {31'd0, pc_write_o}, 32'd1);
    check("ld_after_mem_req", {31'd0, mem_req_o}, 32'd0);

    // Ack on the same cycle the watchdog would expire: access completes
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, c == 4);
      check("race_mem_req", {31'd0, mem_req_o}, 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("race_timeout", {31'd0, timeout_o}, 32'd0);
    check("race_busy", {31'd0, busy_o}, 32'd0);
    check("race_pc_write", {31'd0, pc_write_o}, 32'd1);
    check("race_stall_cnt", stall_count_o, 32'd11);

    // Reset in the second wait cycle
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mrst_wait_req", {31'd0, mem_req_o}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mrst_forced_pc", {31'd0, pc_write_o}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mrst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("mrst_busy", {31'd0, busy_o}, 32'd0);
    check("mrst_pc_write", {31'd0, pc_write_o}, 32'd1);
    check("mrst_stall_cnt", stall_count_o, 32'd0);

    // Store without ack: watchdog restarts from 0, ERR after 4 wait cycles
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("to_wait_mem_req", {31'd0, mem_req_o}, 32'd1);
      check("to_wait_timeout", {31'd0, timeout_o}, 32'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("err_timeout", {31'd0, timeout_o}, 32'd1);
    check("err_busy", {31'd0, busy_o}, 32'd1);
    check("err_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("err_pc_write", {31'd0, pc_write_o}, 32'd0);
    check("err_stall_cnt", stall_count_o, 32'd5);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("err_hold_timeout", {31'd0, timeout_o}, 32'd1);
    check("err_hold_busy", {31'd0, busy_o}, 32'd1);
    check("err_hold_stall_cnt", stall_count_o, 32'd6);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("err_ack_ignored", {31'd0, busy_o}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("clr_timeout", {31'd0, timeout_o}, 32'd0);
    check("clr_busy", {31'd0, busy_o}, 32'd0);
    check("clr_pc_write", {31'd0, pc_write_o}, 32'd1);
    check("clr_stall_cnt", stall_count_o, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Combines three sources into one set of per-stage write-enable, flush and bubble controls: the load-use indication from hazard detection, branch-taken from ID, and a multi-cycle data-memory handshake in MEM.
- Owns the data-memory request/ack protocol, a wait watchdog and a stall-cycle performance counter.

Parameters:
- TIMEOUT, 64, max cycles in MEM_WAIT without mem_ack_i before the ERR state is entered (range 1 to 2^TO_W-1).
- TO_W, 8, width of the watchdog counter.
- CNT_W, 32, width of stall_count_o.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous active-high reset.
- hazard_i  input  1  load-use hazard detected for the instruction in ID.
- branch_taken_i  input  1  branch in ID resolved taken.
- mem_read_i  input  1  instruction in MEM performs a load.
- mem_write_i  input  1  instruction in MEM performs a store.
- mem_ack_i  input  1  data memory has completed the current access.
- mem_req_o  output  1  registered request to data memory, held until ack.
- pc_write_o  output  1  PC update enable.
- ifid_write_o  output  1  IF/ID register update enable.
- ifid_flush_o  output  1  IF/ID loads a NOP.
- idex_bubble_o  output  1  ID/EX loads zeroed control (bubble).
- exmem_write_o  output  1  EX/MEM register update enable.
- memwb_bubble_o  output  1  MEM/WB loads zeroed control.
- busy_o  output  1  high in MEM_WAIT or ERR.
- timeout_o  output  1  sticky watchdog error.
- stall_count_o  output  CNT_W  saturating count of cycles with pc_write_o=0.

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst_i, sampled at the rising edge of clk_i.
- Reset values:
  - state=RUN, mem_req_o=0, timeout_o=0, watchdog=0, stall_count_o=0.
  - While rst_i=1, the combinational outputs are forced to pc_write_o=1, ifid_write_o=1, exmem_write_o=1, ifid_flush_o=0, idex_bubble_o=0, memwb_bubble_o=0.
- Define acc = mem_read_i | mem_write_i.
- FSM states: RUN, MEM_WAIT, MEM_DONE, ERR. Transitions:
  - RUN, acc=1: go to MEM_WAIT; mem_req_o rises on the next edge. In this cycle the pipeline freezes (see freeze).
  - RUN, acc=0: stay in RUN.
  - MEM_WAIT, mem_ack_i=1: go to MEM_DONE; mem_req_o drops.
  - MEM_WAIT, no ack and watchdog=TIMEOUT-1: go to ERR; mem_req_o drops; timeout_o=1.
  - MEM_WAIT otherwise: watchdog increments.
  - MEM_DONE: always go to RUN. acc is not re-evaluated here, because the completed instruction leaves MEM on this edge.
  - ERR: stays until reset.
- Freeze (RUN with acc=1, all of MEM_WAIT, all of ERR):
  - pc_write_o=0, ifid_write_o=0, exmem_write_o=0, memwb_bubble_o=1; flush and bubble outputs 0.
  - hazard_i and branch_taken_i are ignored; they are re-evaluated after release.
- Advance (RUN with acc=0, and MEM_DONE): priority hazard > branch.
  - hazard_i=1: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, exmem_write_o=1.
  - Else if branch_taken_i=1: ifid_flush_o=1, all write enables 1.
  - Else: all write enables 1, all flush/bubble 0.
- hazard_i and branch_taken_i together: only the hazard acts. The branch is re-resolved next cycle with forwarded operands.
- Watchdog: cleared on entry to MEM_WAIT. Total latency from request to ERR is TIMEOUT cycles.
- mem_ack_i outside MEM_WAIT is ignored. An ack on the same edge the watchdog expires wins, so the FSM goes to MEM_DONE.
- stall_count_o increments by 1 every non-reset cycle with pc_write_o=0 and saturates at all-ones.
- Reset mid-MEM_WAIT: the next edge returns to RUN, mem_req_o=0, watchdog=0.

Test Plan:
- Reset, then idle inputs for 5 cycles -> pc_write_o=1, ifid_write_o=1, exmem_write_o=1, mem_req_o=0, stall_count_o=0.
- hazard_i=1 for 1 cycle in RUN -> that cycle pc_write_o=0, ifid_write_o=0, idex_bubble_o=1; stall_count_o=1 afterwards.
- hazard_i=1 and branch_taken_i=1 together -> idex_bubble_o=1, ifid_flush_o=0. Next cycle branch_taken_i=1 alone -> ifid_flush_o=1.
- mem_read_i=1 at cycle 0, mem_ack_i at cycle 3 -> mem_req_o=1 in cycles 1-3; pipeline frozen in cycles 0-3; MEM_DONE at cycle 4 with all writes 1; stall_count_o=4.
- mem_write_i=1 with no ack, TIMEOUT=4 -> mem_req_o high for 4 cycles, then timeout_o=1 and busy_o=1 held. rst_i clears both; pc_write_o=1 after reset.
- rst_i asserted in the 2nd MEM_WAIT cycle -> next cycle state RUN, mem_req_o=0. A later access restarts the watchdog from 0.
